// File: rtl/rename_map_table.sv
// Register alias table: multi-lane rename with in-group forwarding and a circular
// FIFO of full-map checkpoints for single-cycle mispredict recovery.
module rename_map_table #(
  parameter int unsigned ARCH_REGS       = 32,
  parameter int unsigned PHYS_REGS       = 128,
  parameter int unsigned ARCH_ADDR_WIDTH = $clog2(ARCH_REGS),
  parameter int unsigned PHYS_ADDR_WIDTH = $clog2(PHYS_REGS),
  parameter int unsigned RENAME_WIDTH    = 4,
  parameter int unsigned CHECKPOINTS     = 4,
  parameter int unsigned CKPT_ID_WIDTH   = $clog2(CHECKPOINTS)
) (
  input  logic                                            clk,
  input  logic                                            async_rst_n,
  input  logic                                            clk_en,
  input  logic [RENAME_WIDTH-1:0]                         ren_valid,
  input  logic [RENAME_WIDTH-1:0]                         ren_dst_we,
  input  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]    ren_src1,
  input  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]    ren_src2,
  input  logic [RENAME_WIDTH-1:0][ARCH_ADDR_WIDTH-1:0]    ren_dst,
  input  logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0]    ren_new_phys,
  output logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0]    src1_phys,
  output logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0]    src2_phys,
  output logic [RENAME_WIDTH-1:0][PHYS_ADDR_WIDTH-1:0]    old_phys,
  input  logic                                            ckpt_req,
  output logic [CKPT_ID_WIDTH-1:0]                        ckpt_id,
  output logic                                            ckpt_full,
  input  logic                                            ckpt_release,
  input  logic                                            restore_valid,
  input  logic [CKPT_ID_WIDTH-1:0]                        restore_id
);

  localparam logic [CKPT_ID_WIDTH:0]   CntFull = (CKPT_ID_WIDTH + 1)'(CHECKPOINTS);
  localparam logic [CKPT_ID_WIDTH:0]   CntOne  = 1;
  localparam logic [CKPT_ID_WIDTH-1:0] IdOne   = 1;

  logic [PHYS_ADDR_WIDTH-1:0] r_map  [ARCH_REGS];
  logic [PHYS_ADDR_WIDTH-1:0] r_snap [CHECKPOINTS][ARCH_REGS];
  logic [PHYS_ADDR_WIDTH-1:0] w_map_grp [ARCH_REGS];

  logic [CKPT_ID_WIDTH-1:0] r_head, r_tail, w_head_d, w_tail_d;
  logic [CKPT_ID_WIDTH:0]   r_count, w_count_d;
  logic                     r_full, w_full_d;

  logic [RENAME_WIDTH-1:0]  w_wr;
  logic [CKPT_ID_WIDTH-1:0] w_dist;
  logic                     w_rel_ok, w_req_ok, w_restore_live;

  assign w_wr = ren_valid & ren_dst_we;

  // Forwarding: a later (higher) writing lane overrides earlier ones, so scan upward.
  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      src1_phys[k] = r_map[ren_src1[k]];
      src2_phys[k] = r_map[ren_src2[k]];
      old_phys[k]  = r_map[ren_dst[k]];
      for (int j = 0; j < k; j++) begin
        if (w_wr[j] && (ren_dst[j] == ren_src1[k])) src1_phys[k] = ren_new_phys[j];
        if (w_wr[j] && (ren_dst[j] == ren_src2[k])) src2_phys[k] = ren_new_phys[j];
        if (w_wr[j] && (ren_dst[j] == ren_dst[k]))  old_phys[k]  = ren_new_phys[j];
      end
    end
  end

  always_comb begin
    w_map_grp = r_map;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (w_wr[k]) w_map_grp[ren_dst[k]] = ren_new_phys[k];
    end
  end

  assign w_dist         = restore_id - r_head;
  assign w_restore_live = (r_count != '0) && ({1'b0, w_dist} < r_count);
  assign w_rel_ok       = ckpt_release && (r_count != '0);
  // A release in the same cycle frees the slot the request needs.
  assign w_req_ok       = ckpt_req && (!r_full || w_rel_ok);

  always_comb begin
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_count_d = r_count;
    if (restore_valid) begin
      w_tail_d  = restore_id + IdOne;
      w_count_d = {1'b0, w_dist} + CntOne;
      if (ckpt_release && (restore_id != r_head)) begin
        w_head_d  = r_head + IdOne;
        w_count_d = {1'b0, w_dist};
      end
    end else begin
      if (w_rel_ok) begin
        w_head_d  = r_head + IdOne;
        w_count_d = w_count_d - CntOne;
      end
      if (w_req_ok) begin
        w_tail_d  = r_tail + IdOne;
        w_count_d = w_count_d + CntOne;
      end
    end
    w_full_d = (w_count_d == CntFull);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) r_map[i] <= PHYS_ADDR_WIDTH'(i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (clk_en) begin
      if (restore_valid) r_map <= r_snap[restore_id];
      else               r_map <= w_map_grp;
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
      r_full  <= w_full_d;
    end
  end

  // Snapshot storage needs no reset; only slots inside the live range are ever read.
  always_ff @(posedge clk) begin
    if (clk_en && !restore_valid && w_req_ok) r_snap[r_tail] <= w_map_grp;
  end

  assign ckpt_id   = r_tail;
  assign ckpt_full = r_full;

  a_restore_live: assert property (@(posedge clk) disable iff (!async_rst_n)
    (clk_en && restore_valid) |-> w_restore_live);

endmodule

// File: tb/tb_rename_map_table.sv
// Randomized bench for rename_map_table against a sequential rename model with a
// queue of (id, snapshot) checkpoints.
module tb_rename_map_table;

  logic                 clk, async_rst_n, clk_en;
  logic [3:0]           ren_valid, ren_dst_we;
  logic [3:0][4:0]      ren_src1, ren_src2, ren_dst;
  logic [3:0][6:0]      ren_new_phys, src1_phys, src2_phys, old_phys;
  logic                 ckpt_req, ckpt_full, ckpt_release, restore_valid;
  logic [1:0]           ckpt_id, restore_id;

  rename_map_table dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
    .ren_valid    (ren_valid),
    .ren_dst_we   (ren_dst_we),
    .ren_src1     (ren_src1),
    .ren_src2     (ren_src2),
    .ren_dst      (ren_dst),
    .ren_new_phys (ren_new_phys),
    .src1_phys    (src1_phys),
    .src2_phys    (src2_phys),
    .old_phys     (old_phys),
    .ckpt_req     (ckpt_req),
    .ckpt_id      (ckpt_id),
    .ckpt_full    (ckpt_full),
    .ckpt_release (ckpt_release),
    .restore_valid(restore_valid),
    .restore_id   (restore_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       id;
    logic [31:0][6:0] snap;
  } ck_t;

  logic [31:0][6:0] m_map, e_grp;
  logic [3:0][6:0]  e_s1, e_s2, e_old;
  ck_t              q[$];
  int               m_tail;
  int               n_chk, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = 7'(i);
    q.delete();
    m_tail = 0;
  endtask

  // Lanes processed in program order against a working copy of the map.
  task automatic model_lanes();
    logic [31:0][6:0] cur;
    cur = m_map;
    for (int k = 0; k < 4; k++) begin
      e_s1[k]  = cur[ren_src1[k]];
      e_s2[k]  = cur[ren_src2[k]];
      e_old[k] = cur[ren_dst[k]];
      if (ren_valid[k] && ren_dst_we[k]) cur[ren_dst[k]] = ren_new_phys[k];
    end
    e_grp = cur;
  endtask

  task automatic model_edge();
    int  idx;
    bit  rel, req;
    ck_t e;
    model_lanes();
    if (restore_valid) begin
      idx = -1;
      for (int i = 0; i < q.size(); i++) if (q[i].id == restore_id) idx = i;
      if (idx < 0) begin
        check("restore_id_live", 32'(restore_id), 32'hFFFF_FFFF);
      end else begin
        while (q.size() > idx + 1) void'(q.pop_back());
        m_map = q[idx].snap;
        if (ckpt_release && q[0].id != restore_id) void'(q.pop_front());
        m_tail = (int'(restore_id) + 1) % 4;
      end
    end else begin
      m_map = e_grp;
      rel = ckpt_release && (q.size() > 0);
      req = ckpt_req && ((q.size() < 4) || rel);
      if (rel) void'(q.pop_front());
      if (req) begin
        e.id   = 2'(m_tail);
        e.snap = e_grp;
        q.push_back(e);
        m_tail = (m_tail + 1) % 4;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_lanes();
    for (int k = 0; k < 4; k++) begin
      if (ren_valid[k]) begin
        check("src1_phys", 32'(src1_phys[k]), 32'(e_s1[k]));
        check("src2_phys", 32'(src2_phys[k]), 32'(e_s2[k]));
        if (ren_dst_we[k]) check("old_phys", 32'(old_phys[k]), 32'(e_old[k]));
      end
    end
    check("ckpt_id", 32'(ckpt_id), 32'(m_tail));
    check("ckpt_full", 32'(ckpt_full), 32'(q.size() == 4));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clk_en) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_in();
    clk_en = 1'b1; ren_valid = '0; ren_dst_we = '0;
    ren_src1 = '0; ren_src2 = '0; ren_dst = '0; ren_new_phys = '0;
    ckpt_req = 1'b0; ckpt_release = 1'b0; restore_valid = 1'b0; restore_id = '0;
  endtask

  task automatic rand_in();
    for (int k = 0; k < 4; k++) begin
      ren_valid[k]    = 1'($urandom_range(0, 1));
      ren_dst_we[k]   = 1'($urandom_range(0, 1));
      ren_src1[k]     = 5'($urandom_range(0, 31));
      ren_src2[k]     = 5'($urandom_range(0, 7));
      ren_dst[k]      = 5'($urandom_range(0, 7));
      ren_new_phys[k] = 7'($urandom_range(0, 127));
    end
    clk_en        = ($urandom_range(0, 9) != 0);
    ckpt_req      = ($urandom_range(0, 2) == 0);
    ckpt_release  = ($urandom_range(0, 3) == 0);
    restore_valid = 1'b0;
    restore_id    = '0;
    if (q.size() > 0 && $urandom_range(0, 9) == 0) begin
      restore_valid = 1'b1;
      restore_id    = q[$urandom_range(0, q.size() - 1)].id;
    end
  endtask

  task automatic do_reset();
    async_rst_n = 1'b0;
    @(negedge clk);
    async_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rename0(input int dst, input int np, input bit req);
    clear_in();
    ren_valid[0] = 1'b1; ren_dst_we[0] = 1'b1;
    ren_dst[0] = 5'(dst); ren_new_phys[0] = 7'(np); ckpt_req = req;
    settle();
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clear_in();
    async_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    async_rst_n = 1'b1;

    // Basic lookup and write
    clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd5;
    settle(); check("reset_src1", 32'(src1_phys[0]), 32'd5);
    ren_dst_we[0] = 1'b1; ren_dst[0] = 5'd5; ren_new_phys[0] = 7'd40;
    settle(); check("old_phys_first", 32'(old_phys[0]), 32'd5);
    tick();
    clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd5;
    settle(); check("map5_after", 32'(src1_phys[0]), 32'd40);
    tick();

    // Intra-group forwarding
    clear_in(); ren_valid = 4'b0111; ren_dst_we = 4'b0011;
    ren_dst[0] = 5'd3; ren_new_phys[0] = 7'd50;
    ren_src1[1] = 5'd3; ren_dst[1] = 5'd3; ren_new_phys[1] = 7'd51;
    ren_src2[2] = 5'd3;
    settle();
    check("fwd_l1_src1", 32'(src1_phys[1]), 32'd50);
    check("fwd_l1_old", 32'(old_phys[1]), 32'd50);
    check("fwd_l2_src2", 32'(src2_phys[2]), 32'd51);
    tick();
    clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd3;
    settle(); check("map3_after", 32'(src1_phys[0]), 32'd51);
    tick();

    // Fill checkpoints, overflow, req+release while full
    for (int i = 0; i < 4; i++) begin
      clear_in(); ren_valid[0] = 1'b1; ren_dst_we[0] = 1'b1;
      ren_dst[0] = 5'(10 + i); ren_new_phys[0] = 7'(70 + i); ckpt_req = 1'b1;
      settle(); check("fill_id", 32'(ckpt_id), 32'(i));
      tick();
    end
    clear_in(); settle(); check("full_after4", 32'(ckpt_full), 32'd1);
    ckpt_req = 1'b1; tick();
    clear_in(); settle(); check("full_5th_ignored", 32'(ckpt_full), 32'd1);
    check("id_5th_ignored", 32'(ckpt_id), 32'd0);
    ckpt_req = 1'b1; ckpt_release = 1'b1; tick();
    clear_in(); settle(); check("full_req_rel", 32'(ckpt_full), 32'd1);
    check("id_after_reuse", 32'(ckpt_id), 32'd1);
    tick();

    // Restore to a middle checkpoint
    do_reset();
    rename0(20, 20, 1'b1);
    rename0(7, 60, 1'b1);
    rename0(7, 61, 1'b1);
    clear_in(); ren_valid[0] = 1'b1; ren_dst_we[0] = 1'b1;
    ren_dst[0] = 5'd7; ren_new_phys[0] = 7'd99; ckpt_req = 1'b1;
    restore_valid = 1'b1; restore_id = 2'd1;
    settle(); tick();
    clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd7;
    settle();
    check("restore_map7", 32'(src1_phys[0]), 32'd60);
    check("restore_id_next", 32'(ckpt_id), 32'd2);
    check("restore_count", 32'(q.size()), 32'd2);
    tick();

    // Clock enable low: forwarding visible, no state change
    clear_in(); clk_en = 1'b0; ren_valid = 4'b0011; ren_dst_we = 4'b0001;
    ren_dst[0] = 5'd9; ren_new_phys[0] = 7'd70; ren_src1[1] = 5'd9; ckpt_req = 1'b1;
    settle(); check("cen0_fwd", 32'(src1_phys[1]), 32'd70);
    tick();
    clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd9;
    settle(); check("cen0_nochange", 32'(src1_phys[0]), 32'd9);
    check("cen0_id", 32'(ckpt_id), 32'd2);
    tick();

    // Randomized stream with an asynchronous reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        clear_in(); ren_valid[0] = 1'b1; ren_src1[0] = 5'd13;
        #3 async_rst_n = 1'b0;
        #1;
        check("arst_map", 32'(src1_phys[0]), 32'd13);
        check("arst_full", 32'(ckpt_full), 32'd0);
        check("arst_id", 32'(ckpt_id), 32'd0);
        @(negedge clk);
        async_rst_n = 1'b1;
        model_reset();
      end
      rand_in();
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Multi-port register alias table mapping architectural registers to physical registers.
- Each cycle, renames a group of up to RENAME_WIDTH instructions, resolving source and destination dependencies inside the group.
- Holds a circular buffer of full-table checkpoints so a branch mispredict restores the map in one cycle.
- Sits between decode and the reservation stations. The free list supplies new physical tags; the ROB consumes old tags for freeing at commit.

Parameters:
- ARCH_REGS, 32, number of architectural registers
- PHYS_REGS, 128, number of physical registers
- ARCH_ADDR_WIDTH, $clog2(ARCH_REGS), architectural index width
- PHYS_ADDR_WIDTH, $clog2(PHYS_REGS), physical tag width
- RENAME_WIDTH, 4, rename lanes per cycle
- CHECKPOINTS, 4, snapshot slots (power of two, >=2)
- CKPT_ID_WIDTH, $clog2(CHECKPOINTS), checkpoint id width

Ports:
- clk  in  1  clock
- async_rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; when low, no state changes
- ren_valid  in  [RENAME_WIDTH]  lane carries an instruction
- ren_dst_we  in  [RENAME_WIDTH]  lane writes a destination
- ren_src1, ren_src2  in  [RENAME_WIDTH][ARCH_ADDR_WIDTH]  source architectural registers
- ren_dst  in  [RENAME_WIDTH][ARCH_ADDR_WIDTH]  destination architectural register
- ren_new_phys  in  [RENAME_WIDTH][PHYS_ADDR_WIDTH]  free-list tag for the destination
- src1_phys, src2_phys  out  [RENAME_WIDTH][PHYS_ADDR_WIDTH]  renamed sources
- old_phys  out  [RENAME_WIDTH][PHYS_ADDR_WIDTH]  prior mapping of the destination
- ckpt_req  in  1  take a snapshot of the post-group map
- ckpt_id  out  CKPT_ID_WIDTH  id allocated for this cycle's ckpt_req
- ckpt_full  out  1  no free checkpoint slot
- ckpt_release  in  1  free the oldest checkpoint (branch resolved correct)
- restore_valid  in  1  mispredict recovery
- restore_id  in  CKPT_ID_WIDTH  checkpoint to restore

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - map[i]=i for all i < ARCH_REGS.
  - Checkpoint head=tail=0, count=0.
  - ckpt_full=0, ckpt_id=0.
  - Snapshot contents don't-care.
- Reset mid-group discards all in-flight renames and checkpoints.
- Lookups are combinational, same cycle. The map update commits at the rising edge when clk_en=1.
- Lane k src lookup:
  - Return ren_new_phys[j] for the highest j<k with ren_valid[j], ren_dst_we[j] and ren_dst[j]==src.
  - Otherwise return map[src].
- old_phys[k] follows the same forwarding rule using ren_dst[k].
- Multiple lanes writing the same ren_dst: the highest lane wins in the table. Intermediate lanes' old_phys chains correctly, e.g. lane1 old_phys = lane0 new tag.
- Lanes with ren_valid=0 or ren_dst_we=0 neither write nor forward. Their outputs are don't-care but must be X-free.
- Checkpoints:
  - Slots form a circular FIFO; ckpt_id = tail pointer.
  - On ckpt_req with count<CHECKPOINTS, slot[tail] <= post-group map, tail++, count++.
  - ckpt_req while full (and no release) is ignored. Upstream stalls on ckpt_full.
  - ckpt_release with count>0: head++, count--. Release with count==0 is ignored.
  - Simultaneous req+release while full: release frees a slot and the req is accepted. count stays CHECKPOINTS, ckpt_full stays 1.
  - ckpt_full = (count==CHECKPOINTS), registered.
- Restore (highest priority):
  - map <= slot[restore_id]; tail <= restore_id+1 (wrap); count <= distance head..restore_id + 1.
  - Discards all younger checkpoints; restore_id itself is kept.
  - Same-cycle renames and ckpt_req are dropped. ckpt_release still applies if restore_id != head.
  - restore_id outside the live range is a protocol error and is asserted in simulation.
- Pointer arithmetic is modulo CHECKPOINTS. count width is CKPT_ID_WIDTH+1.
- With clk_en=0, outputs remain combinational from current state, with no updates.

Test Plan:
- Reset then lane0 src1=5 -> src1_phys=5; lane0 dst=5, new=40 -> old_phys=5, next cycle map[5]=40.
- Group lane0 dst=3 new=50, lane1 src1=3 dst=3 new=51, lane2 src2=3 -> lane1 src1_phys=50, lane1 old_phys=50, lane2 src2_phys=51, map[3]=51 after edge.
- ckpt_req x4 with renames -> ids 0..3, ckpt_full=1; 5th req ignored; req+release same cycle -> accepted, id 0 reused.
- Checkpoint id1 taken after map[7]=60, then map[7]=61 and ckpt id2; restore_id=1 -> map[7]=60, count=2, next ckpt_id=2, concurrent rename discarded.
- Reset asserted mid-stream asynchronously (between edges) -> map identity immediately, ckpt_full=0, count=0.
- clk_en=0 with valid renames and ckpt_req -> no map or pointer change; outputs still reflect forwarding.
